// File: rtl/airi5c_pipe_stage_buf.sv
// airi5c_pipe_stage_buf
// Elastic DEPTH-entry pipeline stage for the AIRI5C core (DE->EX, EX->WB).
// Entries move through a circular buffer with a valid/ready handshake on both
// sides. A killed entry is stored as KILL_VAL (a NOP-equivalent bubble) and is
// flagged on out_killed_o when it reaches the head. flush_i drops every stored
// entry and wins over a simultaneous push. in_ready_o depends on registered
// state only, so no combinational path runs from out_ready_i to in_ready_o.
// Optional feature: define AIRI5C_PSTAGE_STALL_CNT_EN to add stall_cnt_o, a
// saturating 16-bit count of cycles in which a valid head was not consumed.
module airi5c_pipe_stage_buf #(
   parameter int unsigned       DATA_W   = 64,
   parameter int unsigned       DEPTH    = 2,
   parameter logic [DATA_W-1:0] KILL_VAL = {DATA_W{1'b0}}
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic                       in_kill_i,
   input  logic [DATA_W-1:0]          in_data_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [DATA_W-1:0]          out_data_o,
   output logic                       out_killed_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef AIRI5C_PSTAGE_STALL_CNT_EN
   ,
   output logic [15:0]                stall_cnt_o
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   // Pointers wrap explicitly so that DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

`ifdef AIRI5C_PSTAGE_STALL_CNT_EN
   // Saturating increment: the counter parks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   logic [CNT_W-1:0]  count_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [DATA_W-1:0] data_p0 [DEPTH];
   logic              kill_p0 [DEPTH];
   logic              vld_p0;
   logic              push;
   logic              pop;

   // Handshake decode: flush suppresses both push and pop in the same cycle.
   assign vld_p0       = (count_q != '0);
   assign in_ready_o   = (count_q != CNT_W'(DEPTH));
   assign push         = in_valid_i & in_ready_o & ~flush_i;
   assign pop          = vld_p0 & out_ready_i & ~flush_i;

   // Head of the buffer; empty buffer presents a bubble with the kill flag low.
   assign out_valid_o  = vld_p0;
   assign out_data_o   = vld_p0 ? data_p0[rd_ptr_q] : KILL_VAL;
   assign out_killed_o = vld_p0 & kill_p0[rd_ptr_q];
   assign count_o      = count_q;

   // Occupancy and pointer bookkeeping; flush returns everything to the reset state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else if (flush_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; a killed entry stores the bubble payload instead of in_data_i.
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_p0[wr_ptr_q] <= in_kill_i ? KILL_VAL : in_data_i;
         kill_p0[wr_ptr_q] <= in_kill_i;
      end
   end

`ifdef AIRI5C_PSTAGE_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Counts downstream back-pressure cycles; only reset clears it, flush does not.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else if (vld_p0 & ~out_ready_i) begin
         stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
